// File: rtl/key_debounce_pkg.sv
// Shared state encoding and default 50 MHz timing constants for the pushbutton
// conditioning block.
package key_debounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_REPEAT       = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } kd_state_t;

    localparam int DEF_STABLE_CYCLES = 1000000;   // 20 ms
    localparam int DEF_HOLD_CYCLES   = 25000000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES = 5000000;   // 100 ms
    localparam int DEF_CNT_W         = 25;

    // True when the state drives the debounced level high
    function automatic logic state_is_held(input kd_state_t st);
        logic held_s;
        case (st)
            ST_PRESSED, ST_REPEAT, ST_RELEASE_WAIT: held_s = 1'b1;
            default:                                held_s = 1'b0;
        endcase
        return held_s;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Bundle of the raw key input and the conditioned outputs.
interface key_debounce_if;
    logic key_n;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic step_pulse;

    modport master (
        output key_n,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  step_pulse
    );

    modport slave (
        input  key_n,
        output key_level,
        output press_pulse,
        output release_pulse,
        output step_pulse
    );
endinterface

// File: rtl/key_debounce_chk.sv
// Output invariants of key_debounce, bound alongside each instance.
module key_debounce_chk (
    input logic clk,
    input logic rst_n,
    input logic key_level,
    input logic press_pulse,
    input logic release_pulse,
    input logic step_pulse
);
    a_no_press_and_release: assert property (@(posedge clk) disable iff (!rst_n)
        !(press_pulse && release_pulse));

    a_press_implies_step: assert property (@(posedge clk) disable iff (!rst_n)
        press_pulse |-> (step_pulse && key_level));

    a_release_drops_level: assert property (@(posedge clk) disable iff (!rst_n)
        release_pulse |-> !key_level);
endmodule

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchronizer with a selectable reset value; also reusable for
// the slide switches.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low pushbutton into a clean level, press/release
// strobes and an auto-repeating step strobe for the counter enable.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    key_debounce_if.slave bus
);
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);
    localparam logic             RPT_ON    = (REPEAT_EN != 0);

    logic             sync_q_s;
    logic             key_s;
    kd_state_t        state_r;
    kd_state_t        state_nxt_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_nxt_s;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             step_r;
    logic             press_nxt_s;
    logic             release_nxt_s;
    logic             step_nxt_s;

    // Presets to released so a key held through reset is seen as a new press
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.key_n),
        .q     (sync_q_s)
    );

    assign key_s = ~sync_q_s;

    // State, timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            timer_r   <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            step_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            level_r   <= state_is_held(state_nxt_s);
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            step_r    <= step_nxt_s;
        end
    end

    // Next-state, timer and strobe decode; every state change clears the timer
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r + TIMER_ONE;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        step_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = '0;
                if (key_s) begin
                    state_nxt_s = ST_PRESS_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!key_s) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = '0;
                end else if (timer_r == STABLE_TC) begin
                    state_nxt_s = ST_PRESSED;
                    timer_nxt_s = '0;
                    press_nxt_s = 1'b1;
                    step_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_PRESS_WAIT;
                end
            end
            ST_PRESSED: begin
                if (!key_s) begin
                    state_nxt_s = ST_RELEASE_WAIT;
                    timer_nxt_s = '0;
                end else if (RPT_ON && (timer_r == HOLD_TC)) begin
                    state_nxt_s = ST_REPEAT;
                    timer_nxt_s = '0;
                    step_nxt_s  = 1'b1;
                end else if (timer_r == HOLD_TC) begin
                    // Repeat disabled: park at terminal count instead of wrapping
                    timer_nxt_s = timer_r;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            ST_REPEAT: begin
                if (!key_s) begin
                    state_nxt_s = ST_RELEASE_WAIT;
                    timer_nxt_s = '0;
                end else if (timer_r == REPEAT_TC) begin
                    timer_nxt_s = '0;
                    step_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_REPEAT;
                end
            end
            ST_RELEASE_WAIT: begin
                if (key_s) begin
                    state_nxt_s = ST_PRESSED;
                    timer_nxt_s = '0;
                end else if (timer_r == STABLE_TC) begin
                    state_nxt_s   = ST_IDLE;
                    timer_nxt_s   = '0;
                    release_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RELEASE_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = '0;
            end
        endcase
    end

    assign bus.key_level     = level_r;
    assign bus.press_pulse   = press_r;
    assign bus.release_pulse = release_r;
    assign bus.step_pulse    = step_r;
endmodule

// File: tb/tb_key_debounce.sv
// Table-driven scoreboard bench for key_debounce, with one auto-repeat and one
// no-repeat instance sharing the same key stimulus.
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int ST = 4;
    localparam int HD = 10;
    localparam int RP = 3;
    localparam int CW = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic key_drv = 1'b1;

    always #5 clk = ~clk;

    key_debounce_if bus_r ();
    key_debounce_if bus_n ();
    assign bus_r.key_n = key_drv;
    assign bus_n.key_n = key_drv;

    key_debounce #(.STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .REPEAT_CYCLES(RP),
                   .REPEAT_EN(1), .CNT_W(CW)) dut_rep (
        .clk (clk), .rst_n (rst_n), .bus (bus_r.slave));

    key_debounce #(.STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .REPEAT_CYCLES(RP),
                   .REPEAT_EN(0), .CNT_W(CW)) dut_norep (
        .clk (clk), .rst_n (rst_n), .bus (bus_n.slave));

    key_debounce_chk chk_rep (.clk(clk), .rst_n(rst_n), .key_level(bus_r.key_level),
        .press_pulse(bus_r.press_pulse), .release_pulse(bus_r.release_pulse),
        .step_pulse(bus_r.step_pulse));
    key_debounce_chk chk_norep (.clk(clk), .rst_n(rst_n), .key_level(bus_n.key_level),
        .press_pulse(bus_n.press_pulse), .release_pulse(bus_n.release_pulse),
        .step_pulse(bus_n.step_pulse));

    // {press, release, step, level}
    typedef struct packed {
        logic press;
        logic rel;
        logic step;
        logic lvl;
    } exp_t;

    // Bit i of each mask: key_n low at edge i / output value just after edge i
    typedef struct {
        string       name;
        int          n;
        logic        norep;
        logic [63:0] low_m;
        logic [63:0] press_m;
        logic [63:0] rel_m;
        logic [63:0] step_m;
        logic [63:0] lvl_m;
    } vec_t;

    vec_t vecs[5];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] dut_out(input logic norep);
        if (norep)
            return {bus_n.press_pulse, bus_n.release_pulse, bus_n.step_pulse, bus_n.key_level};
        else
            return {bus_r.press_pulse, bus_r.release_pulse, bus_r.step_pulse, bus_r.key_level};
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d actual(p,r,s,l)=%b required=%b", name, idx, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t e;

        vecs[0] = '{"clean_press", 20, 1'b0, rng(0, 7), rng(6, 6), rng(14, 14),
                    rng(6, 6), rng(6, 13)};
        vecs[1] = '{"bounce", 14, 1'b0, rng(0, 1) | rng(3, 13), rng(9, 9), 64'd0,
                    rng(9, 9), rng(9, 13)};
        vecs[2] = '{"hold_repeat", 28, 1'b0, rng(0, 27), rng(6, 6), 64'd0,
                    rng(6, 6) | rng(16, 16) | rng(19, 19) | rng(22, 22) | rng(25, 25),
                    rng(6, 27)};
        vecs[3] = '{"repeat_glitch", 40, 1'b0, rng(0, 19) | rng(22, 39), rng(6, 6), 64'd0,
                    rng(6, 6) | rng(16, 16) | rng(19, 19) | rng(34, 34) | rng(37, 37),
                    rng(6, 39)};
        vecs[4] = '{"no_repeat", 60, 1'b1, rng(0, 45), rng(6, 6), rng(52, 52),
                    rng(6, 6), rng(6, 51)};

        // Reset values of both instances
        repeat (2) @(negedge clk);
        check("reset_rep", 0, dut_out(1'b0), 4'b0000);
        check("reset_norep", 0, dut_out(1'b1), 4'b0000);

        // Press to the strobe, then reset mid-cycle with the key still held
        rst_n   = 1'b1;
        key_drv = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_reset", 6, dut_out(1'b0), 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 6, dut_out(1'b0), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("held_thru_reset", i, dut_out(1'b0),
                  {(i == 6), 1'b0, (i == 6), (i >= 6)});
        end

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            rst_n   = 1'b0;
            key_drv = 1'b1;
            #1;
            check({vecs[v].name, "_rst"}, 0, dut_out(vecs[v].norep), 4'b0000);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < vecs[v].n; i++) begin
                key_drv = ~vecs[v].low_m[i];
                sb_q.push_back('{vecs[v].press_m[i], vecs[v].rel_m[i],
                                 vecs[v].step_m[i], vecs[v].lvl_m[i]});
                @(posedge clk);
                #1;
                e = sb_q.pop_front();
                check(vecs[v].name, i, dut_out(vecs[v].norep), e);
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
